rst_sequencer: RTL and testbench

//  Board-level reset conditioner upstream of every heartbeat/LED and user block on clk.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_sequencer_btn_debounce.sv | 52 +++++
 rtl/rst_sequencer.sv | 148 ++++++++++++++
 tb/tb_rst_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the board reset sequencer: FSM encoding, default
// parameter values and counter-width helpers.
package rst_seq_pkg;

    // Sequencer states; 2'd3 is unused and recovers to S_HOLD.
    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_BTN  = 2'd2,
        S_ILL  = 2'd3
    } state_t;

    localparam int HOLD_CYCLES_DEF     = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int EVT_WIDTH_DEF       = 8;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int HOLD_W = cnt_width(HOLD_CYCLES_DEF);
    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/rst_sequencer_btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a debounce
// counter that accepts a new level only after it has been stable long enough.
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic a_reset_n,
    input  logic btn_raw,
    output logic btn_stable
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [DW-1:0] r_deb_cnt;
    logic          r_btn_stable;
    logic          w_btn_s;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    assign w_btn_s = r_sync[1];

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_deb_cnt    <= '0;
            r_btn_stable <= 1'b0;
        end else if (w_btn_s != r_btn_stable) begin
            if (r_deb_cnt == DEB_LAST) begin
                r_btn_stable <= w_btn_s;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    assign btn_stable = r_btn_stable;

endmodule

// File: rtl/rst_sequencer.sv
// Board-level reset conditioner. rst_out asserts asynchronously with
// a_reset_n, is stretched by the hold sequence, and always releases
// synchronously through a shift register. Debounced button presses force a
// fresh reset sequence and are counted for debug.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int EVT_WIDTH       = EVT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 a_reset_n,
    input  logic                 btn_raw,
    output logic                 rst_out,
    output logic                 rst_release,
    output logic [EVT_WIDTH-1:0] btn_evt_cnt,
    output logic [1:0]           state_dbg
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [HW-1:0]          r_hold_cnt;
    logic [HW-1:0]          w_hold_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_rel_sr;
    logic                   r_release;
    logic [EVT_WIDTH-1:0]   r_evt_cnt;
    logic                   w_btn_stable;
    logic                   w_evt_inc;
    logic                   w_not_run;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .btn_raw   (btn_raw),
        .btn_stable(w_btn_stable)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next hold count; a held button always wins over hold expiry.
    always_comb begin
        w_state_nxt    = S_HOLD;
        w_hold_cnt_nxt = '0;
        case (r_state)
            S_HOLD: begin
                if (w_btn_stable) begin
                    w_state_nxt = S_BTN;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt    = S_HOLD;
                    w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                end
            end
            S_RUN: begin
                if (w_btn_stable) begin
                    w_state_nxt = S_BTN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_BTN: begin
                if (w_btn_stable) begin
                    w_state_nxt = S_BTN;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    // FSM outputs: button-reset strobe and the reset request fed to the release chain.
    always_comb begin
        w_evt_inc = 1'b0;
        w_not_run = 1'b1;
        case (r_state)
            S_RUN: begin
                w_evt_inc = w_btn_stable;
                w_not_run = 1'b0;
            end
            default: begin
                w_evt_inc = 1'b0;
                w_not_run = 1'b1;
            end
        endcase
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Release chain: set asynchronously, cleared only by shifting zeros in from clk.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_rel_sr <= '1;
        end else begin
            r_rel_sr <= {r_rel_sr[SYNC_STAGES-2:0], w_not_run};
        end
    end

    // One-cycle pulse coinciding with the first cycle rst_out reads low.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_release <= 1'b0;
        end else begin
            r_release <= ~r_rel_sr[SYNC_STAGES-2] & r_rel_sr[SYNC_STAGES-1];
        end
    end

    // Saturating count of accepted button resets.
    always_ff @(posedge clk or posedge a_reset_n) begin
        if (a_reset_n) begin
            r_evt_cnt <= '0;
        end else if (w_evt_inc && (r_evt_cnt != {EVT_WIDTH{1'b1}})) begin
            r_evt_cnt <= r_evt_cnt + EVT_WIDTH'(1);
        end else begin
            r_evt_cnt <= r_evt_cnt;
        end
    end

    assign rst_out     = r_rel_sr[SYNC_STAGES-1];
    assign rst_release = r_release;
    assign btn_evt_cnt = r_evt_cnt;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer. A behavioural model built from the
// sequencer's rules (sample history, debounce window, hold timing, release
// delay) predicts every output each cycle; scenario tasks add fixed checks.
`timescale 1ns/1ps
module tb_rst_sequencer;

    localparam int H = 16;
    localparam int D = 8;
    localparam int S = 2;
    localparam int E = 8;

    logic         clk       = 1'b0;
    logic         a_reset_n = 1'b0;
    logic         btn_raw   = 1'b0;
    logic         rst_out;
    logic         rst_release;
    logic [E-1:0] btn_evt_cnt;
    logic [1:0]   state_dbg;
    logic [E+3:0] obs;

    int vecs = 0;
    int errs = 0;

    rst_sequencer #(
        .HOLD_CYCLES(H), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .EVT_WIDTH(E)
    ) dut (
        .clk(clk), .a_reset_n(a_reset_n), .btn_raw(btn_raw),
        .rst_out(rst_out), .rst_release(rst_release),
        .btn_evt_cnt(btn_evt_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {rst_out, rst_release, state_dbg, btn_evt_cnt};

    // ---------------- reference model ----------------
    bit raw_q[$];   // [0] = btn_raw at previous edge, [1] = two edges ago
    bit win_q[$];   // last D synchronised samples seen by the debouncer
    bit nr_q[$];    // "not running" after each of the last S edges, newest first
    bit m_stable, m_rst, m_rel;
    int m_mode, m_evt, m_t, m_hold_entry;

    function automatic void model_reset();
        raw_q.delete(); win_q.delete(); nr_q.delete();
        for (int i = 0; i < 2; i++) raw_q.push_back(1'b0);
        for (int i = 0; i < D; i++) win_q.push_back(1'b0);
        for (int i = 0; i < S; i++) nr_q.push_back(1'b1);
        m_stable = 1'b0; m_rst = 1'b1; m_rel = 1'b0;
        m_mode = 0; m_evt = 0; m_t = 0; m_hold_entry = 0;
    endfunction

    function automatic void model_step(input bit raw);
        bit bs, flip, old_rst;
        int nm;
        m_t++;
        bs = raw_q[1];
        raw_q.push_front(raw); void'(raw_q.pop_back());
        win_q.push_front(bs); void'(win_q.pop_back());
        flip = 1'b1;
        foreach (win_q[i]) if (win_q[i] == m_stable) flip = 1'b0;
        nm = m_mode;
        case (m_mode)
            0: if (m_stable) nm = 2;
               else if (m_t - m_hold_entry == H) nm = 1;
            1: if (m_stable) begin
                   nm = 2;
                   if (m_evt < (1 << E) - 1) m_evt++;
               end
            2: if (!m_stable) begin nm = 0; m_hold_entry = m_t; end
            default: nm = 0;
        endcase
        if (flip) m_stable = bs;
        old_rst = m_rst;
        m_rst = nr_q[S-1];
        nr_q.push_front(nm != 1); void'(nr_q.pop_back());
        m_rel = old_rst && !m_rst;
        m_mode = nm;
    endfunction

    function automatic logic [E+3:0] exp_vec();
        logic [1:0] md;
        logic [E-1:0] ev;
        md = m_mode[1:0];
        ev = m_evt[E-1:0];
        return {m_rst, m_rel, md, ev};
    endfunction

    // One clock: advance the model at the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (a_reset_n) model_reset(); else model_step(btn_raw);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, hold it for n edges, release before an edge.
    task automatic pulse_reset(input int n);
        #2 a_reset_n = 1'b1;
        model_reset();
        repeat (n) tick();
        a_reset_n = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_power_on();
        int fall;
        #2 a_reset_n = 1'b1;
        model_reset();
        repeat (5) tick();
        vecs++;
        if (obs !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            errs++; $display("FAIL reset_state got %h exp %h", obs, {1'b1, 1'b0, 2'd0, 8'd0});
        end
        a_reset_n = 1'b0;
        fall = 0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL power_on edge %0d got %h exp %h", e, obs, exp_vec());
            end
            if (fall == 0 && rst_out === 1'b0) begin
                fall = e;
                vecs++;
                if (rst_release !== 1'b1 || state_dbg !== 2'd1) begin
                    errs++; $display("FAIL power_on_release rel %b state %0d exp 1/1", rst_release, state_dbg);
                end
            end
        end
        vecs++;
        if (fall != H + S) begin
            errs++; $display("FAIL power_on_latency got %0d exp %0d", fall, H + S);
        end
    endtask

    task automatic test_bounce();
        logic [E-1:0] evt0;
        evt0 = btn_evt_cnt;
        for (int i = 0; i < 100; i++) begin
            btn_raw = ((i / 3) % 2) == 1;
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL bounce cyc %0d got %h exp %h", i, obs, exp_vec());
            end
        end
        btn_raw = 1'b0;
        repeat (12) tick();
        vecs++;
        if (rst_out !== 1'b0 || btn_evt_cnt !== evt0) begin
            errs++; $display("FAIL bounce_end rst %b evt %0d exp 0/%0d", rst_out, btn_evt_cnt, evt0);
        end
    endtask

    task automatic test_clean_press();
        logic [E-1:0] evt0;
        int fall, pulses;
        evt0 = btn_evt_cnt;
        btn_raw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL press_held cyc %0d got %h exp %h", i, obs, exp_vec());
            end
        end
        vecs++;
        if (rst_out !== 1'b1 || btn_evt_cnt !== evt0 + 8'd1) begin
            errs++; $display("FAIL press_count rst %b evt %0d exp 1/%0d", rst_out, btn_evt_cnt, evt0 + 8'd1);
        end
        btn_raw = 1'b0;
        fall = 0; pulses = 0;
        for (int e = 1; e <= 45; e++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL press_release edge %0d got %h exp %h", e, obs, exp_vec());
            end
            if (rst_release === 1'b1) pulses++;
            if (fall == 0 && rst_out === 1'b0) fall = e;
        end
        // debounce (D+2), leave S_BTN (1), hold (H), release chain (S)
        vecs++;
        if (fall != D + 3 + H + S || pulses != 1) begin
            errs++; $display("FAIL press_relatency got %0d/%0d exp %0d/1", fall, pulses, D + 3 + H + S);
        end
    endtask

    task automatic test_async_assert();
        int fall;
        #2 a_reset_n = 1'b1;
        model_reset();
        #1;
        vecs++;
        if (obs !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            errs++; $display("FAIL async_assert got %h exp %h", obs, {1'b1, 1'b0, 2'd0, 8'd0});
        end
        @(negedge clk);
        repeat (2) tick();
        a_reset_n = 1'b0;
        fall = 0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL async_rerelease edge %0d got %h exp %h", e, obs, exp_vec());
            end
            if (fall == 0 && rst_out === 1'b0) fall = e;
        end
        vecs++;
        if (fall != H + S) begin
            errs++; $display("FAIL async_latency got %0d exp %0d", fall, H + S);
        end
    endtask

    task automatic test_reset_mid_hold();
        int fall;
        repeat (10) tick();
        pulse_reset(2);
        fall = 0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL mid_hold edge %0d got %h exp %h", e, obs, exp_vec());
            end
            if (fall == 0 && rst_out === 1'b0) fall = e;
        end
        vecs++;
        if (fall != H + S) begin
            errs++; $display("FAIL mid_hold_latency got %0d exp %0d", fall, H + S);
        end
    endtask

    task automatic test_btn_at_hold_end();
        // Raw press sampled at edge 6 is accepted at edge 15, so the FSM sees
        // it on edge 16 -- the same edge the hold count would expire.
        pulse_reset(2);
        for (int e = 1; e <= 16; e++) begin
            if (e == 6) btn_raw = 1'b1;
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL hold_end edge %0d got %h exp %h", e, obs, exp_vec());
            end
        end
        vecs++;
        if (state_dbg !== 2'd2 || btn_evt_cnt !== 8'd0) begin
            errs++; $display("FAIL hold_end_btn_wins state %0d evt %0d exp 2/0", state_dbg, btn_evt_cnt);
        end
        repeat (4) tick();
        btn_raw = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL hold_end_recover cyc %0d got %h exp %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
            btn_raw = $urandom_range(0, 1) == 1;
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                tick();
                vecs++;
                if (obs !== exp_vec()) begin
                    errs++; $display("FAIL random seg %0d cyc %0d got %h exp %h", seg, i, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        btn_raw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            vecs++;
            if (obs !== exp_vec()) begin
                errs++; $display("FAIL sat_settle cyc %0d got %h exp %h", i, obs, exp_vec());
            end
        end
        for (int p = 0; p < 260; p++) begin
            for (int i = 0; i < 47; i++) begin
                btn_raw = (i < 12);
                tick();
                vecs++;
                if (obs !== exp_vec()) begin
                    errs++; $display("FAIL saturation press %0d cyc %0d got %h exp %h", p, i, obs, exp_vec());
                end
            end
        end
        vecs++;
        if (btn_evt_cnt !== 8'hFF) begin
            errs++; $display("FAIL saturation_final got %0d exp 255", btn_evt_cnt);
        end
    endtask

    initial begin
        test_power_on();
        test_bounce();
        test_clean_press();
        test_async_assert();
        test_reset_mid_hold();
        test_btn_at_hold_end();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
